// File: rtl/al_timekeeper_pkg.sv
// al_timekeeper_pkg: shared BCD limits, ring state encoding and BCD helpers for the alarm clock timekeeper.
package al_timekeeper_pkg;

    localparam logic [7:0] HOUR_MAX_BCD = 8'h23;
    localparam logic [7:0] MIN_MAX_BCD  = 8'h59;
    localparam logic [7:0] SEC_MAX_BCD  = 8'h59;

    typedef enum logic {
        RING_IDLE = 1'b0,
        RING_ON   = 1'b1
    } ring_state_t;

    // Two-digit BCD successor that wraps to 00 after max, never emitting a binary 0x0A.
    function automatic logic [7:0] bcd_next(input logic [7:0] q, input logic [7:0] max);
        return (q == max) ? 8'h00 : (q[3:0] == 4'd9) ? {q[7:4] + 4'd1, 4'd0} : q + 8'd1;
    endfunction

    function automatic logic hhmm_valid(input logic [15:0] k);
        return (k[15:12] <= 4'd9) && (k[11:8] <= 4'd9) && (k[7:4] <= 4'd9) && (k[3:0] <= 4'd9) &&
               (k[15:8] <= HOUR_MAX_BCD) && (k[7:0] <= MIN_MAX_BCD);
    endfunction

endpackage

// File: rtl/al_timekeeper_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping at MAX, with synchronous load and carry on wrap.
module bcd_mod_counter
    import al_timekeeper_pkg::*;
#(
    parameter logic [7:0] MAX = SEC_MAX_BCD
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       carry_out
);

    logic [7:0] r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_q <= 8'h00;
        else if (load)
            r_q <= d;
        else if (inc)
            r_q <= bcd_next(r_q, MAX);
    end

    assign q         = r_q;
    assign carry_out = inc && (r_q == MAX);

endmodule

// File: rtl/al_timekeeper.sv
// al_timekeeper: running BCD HH:MM:SS, validated time/alarm loads, alarm ring FSM and display mux.
module al_timekeeper
    import al_timekeeper_pkg::*;
#(
    parameter logic [7:0] RING_SECONDS = 8'd60,
    parameter int         TWELVE_HOUR  = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        one_second,
    input  logic [15:0] key_buffer,
    input  logic        load_new_time,
    input  logic        load_alarm,
    input  logic        show_alarm,
    input  logic        show_keyboard,
    input  logic        stop_alarm,
    output logic [15:0] display,
    output logic [7:0]  seconds,
    output logic        sound_alarm,
    output logic        alarm_armed,
    output logic        load_error
);

    if (TWELVE_HOUR != 0) begin : g_twelve_hour_unsupported
        $error("al_timekeeper supports 24-hour mode only (TWELVE_HOUR must be 0)");
    end

    logic        w_key_ok, w_ld_time, w_ld_alarm, w_tick, w_match;
    logic        w_ss_carry, w_mm_carry, w_hh_carry;
    logic [7:0]  w_ss, w_mm, w_hh, w_next_mm, w_next_hh;
    logic [15:0] r_alarm;
    logic        r_armed, r_load_error;
    logic [7:0]  r_ring_cnt;
    ring_state_t r_state, w_state_next;

    assign w_key_ok   = hhmm_valid(key_buffer);
    assign w_ld_time  = load_new_time && w_key_ok;
    assign w_ld_alarm = load_alarm && w_key_ok;
    // A valid time load swallows a same-cycle tick.
    assign w_tick     = one_second && !w_ld_time;

    bcd_mod_counter #(.MAX(SEC_MAX_BCD)) u_ss (
        .clk(clk), .reset_n(reset_n), .inc(w_tick), .load(w_ld_time),
        .d(8'h00), .q(w_ss), .carry_out(w_ss_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX_BCD)) u_mm (
        .clk(clk), .reset_n(reset_n), .inc(w_ss_carry), .load(w_ld_time),
        .d(key_buffer[7:0]), .q(w_mm), .carry_out(w_mm_carry)
    );

    bcd_mod_counter #(.MAX(HOUR_MAX_BCD)) u_hh (
        .clk(clk), .reset_n(reset_n), .inc(w_mm_carry), .load(w_ld_time),
        .d(key_buffer[15:8]), .q(w_hh), .carry_out(w_hh_carry)
    );

    // HH:MM as it will be after this edge; only consulted when seconds roll over to 00.
    assign w_next_mm = w_mm_carry ? 8'h00 : bcd_next(w_mm, MIN_MAX_BCD);
    assign w_next_hh = w_hh_carry ? 8'h00 : w_mm_carry ? bcd_next(w_hh, HOUR_MAX_BCD) : w_hh;
    assign w_match   = w_ss_carry && r_armed && ({w_next_hh, w_next_mm} == r_alarm);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alarm      <= 16'h0000;
            r_armed      <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_load_error <= (load_new_time || load_alarm) && !w_key_ok;
            if (w_ld_alarm) begin
                r_alarm <= key_buffer;
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= RING_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = (r_state == RING_IDLE) ? (w_match ? RING_ON : RING_IDLE) :
                       (stop_alarm || (!w_match && one_second && r_ring_cnt <= 8'd1)) ? RING_IDLE : RING_ON;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ring_cnt <= 8'd0;
        else if (w_state_next == RING_IDLE)
            r_ring_cnt <= 8'd0;
        else if (w_match)
            r_ring_cnt <= RING_SECONDS;
        else if (one_second)
            r_ring_cnt <= r_ring_cnt - 8'd1;
    end

    always_comb begin
        sound_alarm = (r_state == RING_ON);
        display     = show_keyboard ? key_buffer : show_alarm ? r_alarm : {w_hh, w_mm};
        seconds     = w_ss;
        alarm_armed = r_armed;
        load_error  = r_load_error;
    end

endmodule

// File: tb/tb_al_timekeeper.sv
// tb_al_timekeeper: randomized + directed scoreboard bench; model keeps time as seconds-of-day and alarm as minute-of-day.
module tb_al_timekeeper;

    localparam int RING = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        one_second = 1'b0;
    logic [15:0] key_buffer = 16'h0000;
    logic        load_new_time = 1'b0;
    logic        load_alarm = 1'b0;
    logic        show_alarm = 1'b0;
    logic        show_keyboard = 1'b0;
    logic        stop_alarm = 1'b0;
    logic [15:0] display;
    logic [7:0]  seconds;
    logic        sound_alarm, alarm_armed, load_error;

    always #5 clk = ~clk;

    al_timekeeper #(.RING_SECONDS(8'(RING)), .TWELVE_HOUR(0)) dut (
        .clk(clk), .reset_n(reset_n), .one_second(one_second), .key_buffer(key_buffer),
        .load_new_time(load_new_time), .load_alarm(load_alarm), .show_alarm(show_alarm),
        .show_keyboard(show_keyboard), .stop_alarm(stop_alarm), .display(display),
        .seconds(seconds), .sound_alarm(sound_alarm), .alarm_armed(alarm_armed), .load_error(load_error)
    );

    typedef struct packed {
        int          tag;
        logic [15:0] disp;
        logic [7:0]  sec;
        logic        snd;
        logic        arm;
        logic        lerr;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   n_step = 0;
    bit   done = 0;
    bit   drained = 0;

    int m_t = 0, m_al = 0, m_cnt = 0;
    bit m_armed = 0, m_ring = 0;

    function automatic logic [7:0] bcd2(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int key_min(input logic [15:0] k);
        return (int'(k[15:12]) * 10 + int'(k[11:8])) * 60 + int'(k[7:4]) * 10 + int'(k[3:0]);
    endfunction

    function automatic bit key_ok(input logic [15:0] k);
        return k[15:12] <= 4'd9 && k[11:8] <= 4'd9 && k[7:4] <= 4'd9 && k[3:0] <= 4'd9 &&
               (int'(k[15:12]) * 10 + int'(k[11:8])) <= 23 && (int'(k[7:4]) * 10 + int'(k[3:0])) <= 59;
    endfunction

    task automatic cmp(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, tag, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("display", e.tag, 32'(display), 32'(e.disp));
            cmp("seconds", e.tag, 32'(seconds), 32'(e.sec));
            cmp("sound_alarm", e.tag, 32'(sound_alarm), 32'(e.snd));
            cmp("alarm_armed", e.tag, 32'(alarm_armed), 32'(e.arm));
            cmp("load_error", e.tag, 32'(load_error), 32'(e.lerr));
        end
        if (done && !drained) begin
            drained = 1;
            cmp("scoreboard_drain", -1, 32'(q.size()), 32'd0);
        end
    end

    task automatic step(input bit rst, input bit tick, input bit lt, input bit la, input bit stp,
                        input bit sk, input bit sa, input logic [15:0] key);
        bit   ok, match, lerr;
        exp_t x;
        @(negedge clk);
        reset_n = rst; one_second = tick; load_new_time = lt; load_alarm = la;
        stop_alarm = stp; show_keyboard = sk; show_alarm = sa; key_buffer = key;
        lerr = 0;
        if (!rst) begin
            m_t = 0; m_al = 0; m_armed = 0; m_ring = 0; m_cnt = 0;
        end else begin
            ok = key_ok(key);
            lerr = (lt || la) && !ok;
            match = 0;
            if (lt && ok)
                m_t = key_min(key) * 60;
            else if (tick) begin
                m_t = (m_t + 1) % 86400;
                match = m_armed && (m_t % 60 == 0) && (m_t / 60 == m_al);
            end
            if (la && ok) begin
                m_al = key_min(key);
                m_armed = 1;
            end
            if (m_ring) begin
                if (stp) m_ring = 0;
                else if (match) m_cnt = RING;
                else if (tick) begin
                    m_cnt--;
                    if (m_cnt == 0) m_ring = 0;
                end
            end else if (match) begin
                m_ring = 1;
                m_cnt = RING;
            end
        end
        x.tag  = n_step++;
        x.disp = sk ? key : sa ? {bcd2(m_al / 60), bcd2(m_al % 60)} : {bcd2(m_t / 3600), bcd2((m_t / 60) % 60)};
        x.sec  = bcd2(m_t % 60);
        x.snd  = m_ring;
        x.arm  = m_armed;
        x.lerr = lerr;
        q.push_back(x);
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1, 1, 0, 0, 0, 0, 0, 16'h0000);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 0, 0, 0, 0, 0, 0, 16'h0000);
    endtask

    task automatic load_time(input logic [15:0] k);
        step(1, 0, 1, 0, 0, 0, 0, k);
    endtask

    task automatic load_alm(input logic [15:0] k);
        step(1, 0, 0, 1, 0, 0, 0, k);
    endtask

    logic [15:0] bad_keys [3];
    logic [15:0] rk;
    int          r, base;

    initial begin
        bad_keys[0] = 16'h2460; bad_keys[1] = 16'h12F5; bad_keys[2] = 16'h0A00;
        step(0, 0, 0, 0, 0, 0, 0, 16'h0000);
        step(0, 1, 0, 0, 0, 0, 0, 16'h2359);
        idle(1);
        ticks(5);
        idle(1);
        load_time(16'h2359);
        ticks(60);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            load_time(bad_keys[i]);
            idle(1);
        end
        for (int i = 0; i < 3; i++) begin
            load_alm(bad_keys[i]);
            idle(1);
        end
        load_alm(16'h0701);
        load_time(16'h0700);
        ticks(60);
        idle(2);
        ticks(3);
        idle(2);
        load_time(16'h0700);
        ticks(60);
        step(1, 0, 0, 0, 1, 0, 0, 16'h0000);
        idle(2);
        load_time(16'h0959);
        ticks(59);
        step(1, 1, 1, 0, 0, 0, 0, 16'h1000);
        idle(1);
        step(1, 0, 0, 0, 0, 1, 1, 16'h1234);
        step(1, 0, 0, 0, 0, 0, 1, 16'h1234);
        step(1, 0, 0, 0, 0, 0, 0, 16'h1234);
        load_time(16'h0700);
        ticks(61);
        step(0, 1, 0, 0, 0, 0, 0, 16'h0000);
        idle(2);
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) begin
                base = $urandom_range(0, 1438);
                load_time({bcd2(base / 60), bcd2(base % 60)});
                if ($urandom_range(0, 3) != 0) load_alm({bcd2((base + 1) / 60), bcd2((base + 1) % 60)});
            end
            r = $urandom_range(0, 999);
            rk = ($urandom_range(0, 3) == 0) ? 16'($urandom) :
                 {bcd2($urandom_range(0, 23)), bcd2($urandom_range(0, 59))};
            step(r != 7, $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, rk);
        end
        idle(1);
        done = 1;
        repeat (2) @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
